// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between the host register interface and the UART core.
// Level counter, almost-full, sticky overflow/underflow flags and synchronous flush.
module uart_byte_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  glb_clk,
  input  logic                  glb_rstn,
  input  logic                  w_en,
  input  logic [DATA_W-1:0]     w_data,
  input  logic                  r_en,
  output logic [DATA_W-1:0]     r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_AFULL = (DEPTH_LOG2 + 1)'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_unf_set;

  assign full        = (r_level == LVL_FULL);
  assign empty       = (r_level == '0);
  assign almost_full = (r_level >= LVL_AFULL);
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign r_data      = empty ? '0 : r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a push while full still goes in.
  assign w_push    = w_en & (~full | r_en) & ~flush;
  assign w_pop     = r_en & ~empty & ~flush;
  assign w_ovf_set = w_en & full & ~r_en & ~flush;
  assign w_unf_set = r_en & empty & ~flush;

  always_ff @(posedge glb_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_ONE;
          2'b01:   r_level <= r_level - LVL_ONE;
          default: r_level <= r_level;
        endcase
      end

      // A new error in the same cycle as err_clr takes precedence.
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_unf_set)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboard bench for uart_byte_fifo: a queue-based reference model predicts
// the post-edge outputs of each cycle; a monitor compares them against the DUT.
module tb_uart_byte_fifo;

  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic           glb_clk = 1'b0;
  logic           glb_rstn;
  logic           w_en;
  logic [DW-1:0]  w_data;
  logic           r_en;
  logic [DW-1:0]  r_data;
  logic           full;
  logic           empty;
  logic           almost_full;
  logic [DL2:0]   level;
  logic           flush;
  logic           err_clr;
  logic           overflow;
  logic           underflow;

  uart_byte_fifo #(
    .DATA_W      (DW),
    .DEPTH_LOG2  (DL2),
    .AFULL_THRESH(AFT)
  ) dut (
    .glb_clk    (glb_clk),
    .glb_rstn   (glb_rstn),
    .w_en       (w_en),
    .w_data     (w_data),
    .r_en       (r_en),
    .r_data     (r_data),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .level      (level),
    .flush      (flush),
    .err_clr    (err_clr),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 glb_clk = ~glb_clk;

  typedef struct {
    int       lvl;
    int       rd;
    bit       f;
    bit       e;
    bit       af;
    bit       ov;
    bit       un;
    string    tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_ov;
  bit         m_un;
  int         pass_cnt = 0;
  int         tot_cnt  = 0;
  int         cyc      = 0;
  string      cur_tag  = "reset";

  task automatic chk(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic exp_t model_view();
    exp_t x;
    x.lvl = mq.size();
    x.rd  = (mq.size() > 0) ? int'(mq[0]) : 0;
    x.f   = (mq.size() == DEPTH);
    x.e   = (mq.size() == 0);
    x.af  = (mq.size() >= AFT);
    x.ov  = m_ov;
    x.un  = m_un;
    x.tag = cur_tag;
    return x;
  endfunction

  task automatic compare_all(input exp_t x, input string where);
    chk({where, " level"},       int'(level),       x.lvl);
    chk({where, " r_data"},      int'(r_data),      x.rd);
    chk({where, " full"},        int'(full),        int'(x.f));
    chk({where, " empty"},       int'(empty),       int'(x.e));
    chk({where, " almost_full"}, int'(almost_full), int'(x.af));
    chk({where, " overflow"},    int'(overflow),    int'(x.ov));
    chk({where, " underflow"},   int'(underflow),   int'(x.un));
  endtask

  // Drive one cycle of stimulus and predict what the following edge produces.
  task automatic step(input bit rn, input bit we, input logic [7:0] wd,
                      input bit re, input bit fl, input bit ec);
    bit sz_full, sz_empty, do_pop, do_push;
    @(negedge glb_clk);
    glb_rstn = rn; w_en = we; w_data = wd; r_en = re; flush = fl; err_clr = ec;
    if (!rn) begin
      mq.delete(); m_ov = 0; m_un = 0;
    end else begin
      sz_full  = (mq.size() == DEPTH);
      sz_empty = (mq.size() == 0);
      do_pop   = re && !fl && !sz_empty;
      do_push  = we && !fl && (!sz_full || re);
      if (fl) mq.delete();
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(wd);
      if (we && !fl && sz_full && !re) m_ov = 1;
      else if (ec) m_ov = 0;
      if (re && !fl && sz_empty) m_un = 1;
      else if (ec) m_un = 0;
    end
    exp_q.push_back(model_view());
  endtask

  task automatic idle(); step(1, 0, 8'h00, 0, 0, 0); endtask

  // Monitor: one expected record per clock, checked just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge glb_clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        compare_all(x, $sformatf("%s@c%0d", x.tag, cyc));
        $display("cyc %0d [%s] lvl=%0d rd=%02h f=%0b e=%0b af=%0b ov=%0b un=%0b",
                 cyc, x.tag, level, r_data, full, empty, almost_full, overflow, underflow);
      end
    end
  end

  initial begin
    exp_t rst_x;
    int   guard;
    logic [7:0] b;
    glb_rstn = 0; w_en = 0; w_data = 0; r_en = 0; flush = 0; err_clr = 0;
    m_ov = 0; m_un = 0;

    cur_tag = "reset";
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h77, 1, 0, 0);
    cur_tag = "idle";
    repeat (2) idle();

    cur_tag = "fill";
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h11 + i), 0, 0, 0);
    cur_tag = "ovf";
    step(1, 1, 8'hAA, 0, 0, 0);
    cur_tag = "full_rw";
    step(1, 1, 8'hBB, 1, 0, 0);
    cur_tag = "drain";
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);

    cur_tag = "unf";
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 8'h5C, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    cur_tag = "wrap";
    for (int i = 0; i < 3; i++) step(1, 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 8'(3 + i), 1, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0, 0);

    cur_tag = "flush";
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hC0 + i), 0, 0, 0);
    step(1, 1, 8'hEE, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 8'h3D, 0, 0, 0);
    idle();

    cur_tag = "rand";
    for (int i = 0; i < 500; i++) begin
      bit we, re, fl, ec;
      b  = 8'($urandom);
      we = (i < 250) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
      re = (i < 250) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 2);
      ec = ($urandom_range(0, 99) < 6);
      step(1, we, b, re, fl, ec);
    end

    // Load a few entries, then drop reset between edges and look at once.
    cur_tag = "async_rst";
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h90 + i), 0, 0, 0);
    step(1, 1, 8'h99, 0, 0, 0);
    @(negedge glb_clk);
    #2;
    glb_rstn = 0;
    #1;
    mq.delete(); m_ov = 0; m_un = 0;
    rst_x = model_view();
    compare_all(rst_x, "async_rst_immediate");
    step(0, 1, 8'h44, 1, 0, 0);
    cur_tag = "post_rst";
    step(1, 1, 8'h44, 0, 0, 0);
    idle();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge glb_clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
